// File: rtl/pipeline_pkg.sv
// Shared definitions for the in-order pipeline controller:
// FSM encoding, stage-valid bit positions and the default register-index width.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FREEZE = 2'd3
  } state_t;

  localparam int NUM_STAGES = 4;
  localparam int STG_IFID   = 0;
  localparam int STG_IDEX   = 1;
  localparam int STG_EXMEM  = 2;
  localparam int STG_MEMWB  = 3;

  localparam int REG_W_DEF  = 5;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in ID/EX whose destination feeds either
// source of the IF/ID instruction. x0 is never a real dependency.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             memread,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic             load_use
);

  assign load_use = memread && (rd != '0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: run/fill/freeze sequencing, stall and flush steering,
// and saturating stall/flush event counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  idex_memread_i,
  input  logic [REG_W-1:0]      idex_rd_i,
  input  logic [REG_W-1:0]      ifid_rs1_i,
  input  logic [REG_W-1:0]      ifid_rs2_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_busy_i,
  output logic                  pc_write_o,
  output logic                  ifid_stall_o,
  output logic                  ifid_flush_o,
  output logic                  idex_flush_o,
  output logic                  freeze_o,
  output logic [NUM_STAGES-1:0] valid_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  state_t                state_q, state_d;
  state_t                resume_q, resume_d;
  logic [NUM_STAGES-1:0] valid_q, valid_d, fill_step;
  logic [CNT_W-1:0]      stall_q, flush_q;
  logic                  load_use, active, frozen;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .memread  (idex_memread_i),
    .rd       (idex_rd_i),
    .rs1      (ifid_rs1_i),
    .rs2      (ifid_rs2_i),
    .load_use (load_use)
  );

  // Freeze outranks load-use, which outranks a taken branch. A FREEZE cycle
  // whose busy has already dropped behaves like the state it returns to.
  always_comb begin
    active       = (state_q != ST_IDLE);
    frozen       = active && mem_busy_i;
    freeze_o     = frozen;
    ifid_stall_o = frozen || (active && load_use);
    idex_flush_o = active && !frozen && load_use;
    ifid_flush_o = active && !frozen && !load_use && branch_taken_i;
    pc_write_o   = active && !frozen && !load_use;
  end

  // Fill progress is the valid vector itself, so holding valid_q across a
  // freeze preserves it without a separate counter.
  always_comb begin
    state_d   = state_q;
    resume_d  = resume_q;
    valid_d   = valid_q;
    fill_step = {valid_q[NUM_STAGES-2:0], 1'b1};
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FILL;
          valid_d = fill_step;
        end
      end
      ST_FILL, ST_RUN: begin
        if (!start_i) begin
          state_d = ST_IDLE;
          valid_d = '0;
        end else if (mem_busy_i) begin
          state_d  = ST_FREEZE;
          resume_d = state_q;
        end else if (state_q == ST_FILL) begin
          valid_d = fill_step;
          if (valid_q[STG_EXMEM]) state_d = ST_RUN;
        end
      end
      ST_FREEZE: begin
        if (!start_i) begin
          state_d = ST_IDLE;
          valid_d = '0;
        end else if (!mem_busy_i) begin
          state_d = resume_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      resume_q <= ST_FILL;
      valid_q  <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      valid_q  <= valid_d;
      if (active && !pc_write_o) stall_q <= sat_inc(stall_q);
      if (ifid_flush_o)          flush_q <= sat_inc(flush_q);
    end
  end

  assign valid_o     = valid_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked against a behavioural model of the controller.
module tb_pipeline_ctrl;

  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, memread = 1'b0, branch = 1'b0, busy = 1'b0;
  logic [REG_W-1:0] rd = '0, rs1 = '0, rs2 = '0;

  logic        a_pc, a_istall, a_iflush, a_xflush, a_frz;
  logic [3:0]  a_valid;
  logic [31:0] a_stall, a_flush;
  logic        b_pc, b_istall, b_iflush, b_xflush, b_frz;
  logic [3:0]  b_valid;
  logic [3:0]  b_stall, b_flush;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REG_W(REG_W), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .idex_memread_i(memread),
    .idex_rd_i(rd), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
    .branch_taken_i(branch), .mem_busy_i(busy),
    .pc_write_o(a_pc), .ifid_stall_o(a_istall), .ifid_flush_o(a_iflush),
    .idex_flush_o(a_xflush), .freeze_o(a_frz), .valid_o(a_valid),
    .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
  );

  pipeline_ctrl #(.REG_W(REG_W), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .idex_memread_i(memread),
    .idex_rd_i(rd), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
    .branch_taken_i(branch), .mem_busy_i(busy),
    .pc_write_o(b_pc), .ifid_stall_o(b_istall), .ifid_flush_o(b_iflush),
    .idex_flush_o(b_xflush), .freeze_o(b_frz), .valid_o(b_valid),
    .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: running flag, number of filled stages, pending-return
  // flag after a freeze, and unbounded event counts clipped per counter width.
  bit     m_on = 0;
  bit     m_frz = 0;
  int     m_fill = 0;
  longint m_stall = 0;
  longint m_flush = 0;

  function automatic bit e_lu();
    return memread && (rd != 0) && ((rd == rs1) || (rd == rs2));
  endfunction
  function automatic bit e_pc();     return m_on && !busy && !e_lu(); endfunction
  function automatic bit e_istall(); return m_on && (busy || e_lu()); endfunction
  function automatic bit e_xflush(); return m_on && !busy && e_lu(); endfunction
  function automatic bit e_iflush(); return m_on && !busy && !e_lu() && branch; endfunction
  function automatic bit e_frz();    return m_on && busy; endfunction
  function automatic logic [63:0] e_valid(); return (64'd1 << m_fill) - 64'd1; endfunction
  function automatic logic [63:0] sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_on = 0; m_frz = 0; m_fill = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_on && !e_pc()) m_stall++;
      if (e_iflush())      m_flush++;
      if (!m_on) begin
        if (start) begin m_on = 1; m_fill = 1; end
      end else if (!start) begin
        m_on = 0; m_fill = 0; m_frz = 0;
      end else if (busy)  m_frz = 1;
      else if (m_frz)     m_frz = 0;
      else if (m_fill < 4) m_fill++;
    end
  end

  always @(negedge clk) begin
    chk("pc_write_a",  a_pc,     e_pc());
    chk("ifid_stall_a", a_istall, e_istall());
    chk("ifid_flush_a", a_iflush, e_iflush());
    chk("idex_flush_a", a_xflush, e_xflush());
    chk("freeze_a",    a_frz,    e_frz());
    chk("valid_a",     a_valid,  e_valid());
    chk("stall_cnt_a", a_stall,  sat(m_stall, 32));
    chk("flush_cnt_a", a_flush,  sat(m_flush, 32));
    chk("pc_write_b",  b_pc,     e_pc());
    chk("ifid_stall_b", b_istall, e_istall());
    chk("ifid_flush_b", b_iflush, e_iflush());
    chk("idex_flush_b", b_xflush, e_xflush());
    chk("freeze_b",    b_frz,    e_frz());
    chk("valid_b",     b_valid,  e_valid());
    chk("stall_cnt_b", b_stall,  sat(m_stall, 4));
    chk("flush_cnt_b", b_flush,  sat(m_flush, 4));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", a_valid, 4'b0000);
    chk("rst_pc", a_pc, 1'b0);
    chk("rst_stall", a_stall, 0);
    chk("rst_flush", a_flush, 0);

    // Fill sequence
    start = 1'b1;
    tick(); chk("fill1", a_valid, 4'b0001); chk("fill1_pc", a_pc, 1'b1);
    tick(); chk("fill2", a_valid, 4'b0011);
    tick(); chk("fill3", a_valid, 4'b0111);
    tick(); chk("fill4", a_valid, 4'b1111); chk("run_pc", a_pc, 1'b1);

    // Load-use on rs2
    memread = 1'b1; rd = 5'd5; rs2 = 5'd5; #1;
    chk("lu_pc", a_pc, 1'b0); chk("lu_stall", a_istall, 1'b1); chk("lu_xflush", a_xflush, 1'b1);
    tick(); chk("lu_cnt", a_stall, 1);
    rd = 5'd0; rs2 = 5'd0; #1;
    chk("x0_pc", a_pc, 1'b1); chk("x0_stall", a_istall, 1'b0);
    tick(); chk("x0_cnt", a_stall, 1);

    // Load-use beats branch
    rd = 5'd5; rs2 = 5'd5; branch = 1'b1; #1;
    chk("lub_iflush", a_iflush, 1'b0); chk("lub_xflush", a_xflush, 1'b1);
    tick(); chk("lub_flushcnt", a_flush, 0); chk("lub_stallcnt", a_stall, 2);

    // Three busy cycles with a taken branch
    memread = 1'b0; busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("frz_o", a_frz, 1'b1); chk("frz_iflush", a_iflush, 1'b0);
      tick();
    end
    busy = 1'b0; branch = 1'b0; #1;
    chk("frz_end", a_frz, 1'b0); chk("frz_pc", a_pc, 1'b1); chk("frz_cnt", a_stall, 5);
    tick(); chk("resume_valid", a_valid, 4'b1111); chk("resume_pc", a_pc, 1'b1);
    branch = 1'b1; #1; chk("br_iflush", a_iflush, 1'b1);
    tick(); chk("br_cnt", a_flush, 1); branch = 1'b0;

    // Reset during a freeze entered from FILL
    rst = 1'b1; start = 1'b0; tick(); rst = 1'b0; tick();
    chk("idle_valid", a_valid, 4'b0000);
    start = 1'b1; tick(); tick(); chk("pf_valid", a_valid, 4'b0011);
    busy = 1'b1; #1; chk("pf_frz", a_frz, 1'b1);
    tick(); chk("pf_hold", a_valid, 4'b0011);
    #2 rst = 1'b1; #1;
    chk("rf_frz", a_frz, 1'b0); chk("rf_stall", a_istall, 1'b0); chk("rf_valid", a_valid, 4'b0000);
    chk("rf_scnt", a_stall, 0); chk("rf_fcnt", a_flush, 0); chk("rf_pc", a_pc, 1'b0);
    tick(); busy = 1'b0; start = 1'b0; rst = 1'b0; tick();
    chk("rf_idle", a_valid, 4'b0000);

    // Counter saturation on the 4-bit instance
    start = 1'b1; repeat (4) tick();
    memread = 1'b1; rd = 5'd3; rs1 = 5'd3;
    repeat (14) tick();
    chk("sat14_b", b_stall, 4'hE); chk("sat14_a", a_stall, 14);
    repeat (3) tick();
    chk("sat17_b", b_stall, 4'hF); chk("sat17_a", a_stall, 17);
    memread = 1'b0; rs1 = 5'd0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 49) != 0);
      busy    = ($urandom_range(0, 6) == 0);
      memread = ($urandom_range(0, 2) == 0);
      branch  = ($urandom_range(0, 4) == 0);
      rd      = REG_W'($urandom_range(0, 3));
      rs1     = REG_W'($urandom_range(0, 3));
      rs2     = REG_W'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  level; CPU run enable, sampled each clock.
REQ-006 SHALL have port idex_memread_i  input  1  instruction in ID/EX is a load.
REQ-007 SHALL have port idex_rd_i  input  REG_W  destination register of the ID/EX instruction.
REQ-008 SHALL have port ifid_rs1_i, ifid_rs2_i  input  REG_W each  source registers of the IF/ID instruction.
REQ-009 SHALL have port branch_taken_i  input  1  branch resolved taken in ID.
REQ-010 SHALL have port mem_busy_i  input  1  data memory not ready; freeze request.
REQ-011 SHALL have port pc_write_o  output  1  PC update enable.
REQ-012 SHALL have ports ifid_stall_o, ifid_flush_o, idex_flush_o  output  1 each  pipeline-register controls.
REQ-013 SHALL have port freeze_o  output  1  hold EX/MEM and MEM/WB contents.
REQ-014 SHALL have port valid_o  output  4  stage-valid bits, [0]=IF/ID ... [3]=MEM/WB.
REQ-015 SHALL have ports stall_cnt_o, flush_cnt_o  output  CNT_W each  event counters.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, RUN, FREEZE.
REQ-017 IDLE -> FILL when start_i=1; all enables 0, pc_write_o=0, every stage held.
REQ-018 FILL SHALL shift 1 into valid_o from bit 0 each cycle; after 4 FILL cycles valid_o=4'b1111 and state -> RUN.
REQ-019 Hazard checks (REQ-021/022) SHALL be active in FILL and RUN.
REQ-020 Any state except IDLE SHALL go to IDLE on the next edge when start_i=0, clearing valid_o to 0 (counters kept).
REQ-021 Load-use: idex_memread_i=1 and idex_rd_i!=0 and idex_rd_i equals ifid_rs1_i or ifid_rs2_i SHALL give pc_write_o=0, ifid_stall_o=1, idex_flush_o=1 in the same cycle (combinational).
REQ-022 Branch: branch_taken_i=1 with no load-use SHALL give ifid_flush_o=1, pc_write_o=1.
REQ-023 Load-use SHALL take priority: simultaneous branch_taken_i is ignored, ifid_flush_o=0.
REQ-024 mem_busy_i=1 in FILL or RUN SHALL move to FREEZE next edge; FREEZE asserts freeze_o=1, ifid_stall_o=1, pc_write_o=0, all flushes 0, valid_o held.
REQ-025 FREEZE SHALL also be entered combinationally: freeze_o, ifid_stall_o asserted in the first cycle mem_busy_i=1 rises.
REQ-026 FREEZE -> previous state (FILL or RUN, FILL cycle count preserved) on the first edge with mem_busy_i=0.
REQ-027 mem_busy_i SHALL take priority over load-use and branch; no flush is issued while frozen.
REQ-028 With no hazard in RUN: pc_write_o=1, all stall/flush/freeze outputs 0.
REQ-029 stall_cnt_o SHALL increment by 1 per cycle in which pc_write_o=0 and state is not IDLE; flush_cnt_o per cycle with ifid_flush_o=1.
REQ-030 Counters SHALL saturate at all-ones, no wrap.

Reset
REQ-031 rst_i=1 SHALL immediately force state IDLE, valid_o=0, stall_cnt_o=0, flush_cnt_o=0, pc_write_o=0, all stall/flush/freeze outputs 0, FILL count 0.
REQ-032 Reset mid-FREEZE or mid-FILL SHALL discard all progress; restart needs start_i=1 after rst_i=0.

Structure
REQ-033 State encoding, stage-index constants and REG_W default SHALL live in shared package pipeline_pkg.
REQ-034 Hazard comparison SHALL be sub-module hazard_detect (pure combinational); FSM and counters stay in pipeline_ctrl.

Verification
REQ-035 Reset then start_i=1: valid_o goes 0001,0011,0111,1111 on edges 1-4, then RUN, pc_write_o=1.
REQ-036 RUN, idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5: one cycle pc_write_o=0, ifid_stall_o=1, idex_flush_o=1, stall_cnt_o +1; idex_rd_i=0 same case -> no stall.
REQ-037 Load-use and branch_taken_i=1 same cycle: ifid_flush_o=0, flush_cnt_o unchanged.
REQ-038 mem_busy_i high 3 cycles with branch_taken_i=1: freeze_o=1 for 3 cycles, no flush, stall_cnt_o +3, resume RUN.
REQ-039 rst_i pulsed during FREEZE in FILL (valid_o=0011): all outputs 0 immediately, counters 0, IDLE.
REQ-040 Preload stall_cnt_o near saturation (CNT_W=4, 14 stalls then 3 more): stall_cnt_o stops at 4'hF.
